// File: rtl/pdm_sequencer.sv
// Steps a small table of PDM level words into a PDM core, holding each level
// for a programmable number of cycles, with optional looping and a muting abort.
module pdm_sequencer #(
  parameter  int DEPTH   = 8,
  parameter  int LEVEL_W = 5,
  parameter  int HOLD_W  = 8,
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [LEVEL_W-1:0] cfg_data,
  input  logic [HOLD_W-1:0]  hold,
  input  logic [IDX_W-1:0]   last_idx,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  output logic [LEVEL_W-1:0] pdm_level,
  output logic               pdm_write_en,
  output logic               busy,
  output logic [IDX_W-1:0]   step_idx,
  output logic               done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               loop_q, loop_d;

  logic [LEVEL_W-1:0] level_q, level_d;
  logic               we_q, we_d;
  logic               busy_q, busy_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;

  logic [LEVEL_W-1:0] level_table [DEPTH];
  logic               tbl_we;
  logic [IDX_W-1:0]   idx_next;

  // The table is frozen while a sequence plays so the running pattern stays coherent.
  assign tbl_we   = cfg_we && (state_q == IDLE);
  assign idx_next = idx_q + IDX_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        level_table[i] <= '0;
      end
    end else if (tbl_we) begin
      level_table[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      level_q <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      level_q <= level_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // The first entry is written on the same edge that accepts start, using the
  // live hold input since the latched copy is not yet visible.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    last_d  = last_q;
    loop_d  = loop_q;
    level_d = level_q;
    we_d    = 1'b0;
    busy_d  = busy_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !stop) begin
          hold_d  = hold;
          last_d  = last_idx;
          loop_d  = loop;
          cnt_d   = hold;
          level_d = level_table[0];
          we_d    = 1'b1;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          level_d = '0;
          we_d    = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - HOLD_W'(1);
        end else if (idx_q < last_q) begin
          idx_d   = idx_next;
          level_d = level_table[idx_next];
          we_d    = 1'b1;
          cnt_d   = hold_q;
        end else if (loop_q) begin
          idx_d   = '0;
          level_d = level_table[0];
          we_d    = 1'b1;
          cnt_d   = hold_q;
        end else begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign pdm_level    = level_q;
  assign pdm_write_en = we_q;
  assign busy         = busy_q;
  assign step_idx     = idx_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pdm_sequencer.sv
// Scoreboard bench for pdm_sequencer: stimulus queues the expected write/done
// events with their cycle numbers and a negedge monitor retires them.
module tb_pdm_sequencer;

  localparam int DEPTH   = 8;
  localparam int LEVEL_W = 5;
  localparam int HOLD_W  = 8;
  localparam int IDX_W   = 3;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cfg_we = 1'b0;
  logic [IDX_W-1:0]   cfg_addr = '0;
  logic [LEVEL_W-1:0] cfg_data = '0;
  logic [HOLD_W-1:0]  hold = '0;
  logic [IDX_W-1:0]   last_idx = '0;
  logic               loop = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic [LEVEL_W-1:0] pdm_level;
  logic               pdm_write_en;
  logic               busy;
  logic [IDX_W-1:0]   step_idx;
  logic               done;

  typedef struct {
    int               cyc;
    logic             we;
    logic             dn;
    logic [LEVEL_W-1:0] lvl;
    logic             chk_idx;
    logic [IDX_W-1:0] idx;
    logic             bsy;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  cyc = 0;
  int  checks = 0;
  int  passed = 0;
  int  n;

  pdm_sequencer #(.DEPTH(DEPTH), .LEVEL_W(LEVEL_W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .hold(hold), .last_idx(last_idx), .loop(loop),
    .start(start), .stop(stop), .pdm_level(pdm_level),
    .pdm_write_en(pdm_write_en), .busy(busy), .step_idx(step_idx), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every write strobe or done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1 && (pdm_write_en || done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL unexpected_event: cyc=%0d we=%0b done=%0b level=%0d idx=%0d, required no event",
                 cyc, pdm_write_en, done, pdm_level, step_idx);
      end else begin
        mon_ev = exp_q.pop_front();
        if (cyc != mon_ev.cyc || pdm_write_en != mon_ev.we || done != mon_ev.dn ||
            pdm_level != mon_ev.lvl || busy != mon_ev.bsy ||
            (mon_ev.chk_idx && step_idx != mon_ev.idx)) begin
          $display("[TB] FAIL event: actual cyc=%0d we=%0b done=%0b level=%0d idx=%0d busy=%0b, required cyc=%0d we=%0b done=%0b level=%0d idx=%0d busy=%0b",
                   cyc, pdm_write_en, done, pdm_level, step_idx, busy,
                   mon_ev.cyc, mon_ev.we, mon_ev.dn, mon_ev.lvl, mon_ev.idx, mon_ev.bsy);
        end else begin
          passed++;
        end
      end
    end
  end

  task automatic push_write(input int c, input int lvl, input int idx);
    exp_q.push_back('{cyc: c, we: 1'b1, dn: 1'b0, lvl: LEVEL_W'(lvl), chk_idx: 1'b1,
                      idx: IDX_W'(idx), bsy: 1'b1});
  endtask

  task automatic push_done(input int c, input int lvl);
    exp_q.push_back('{cyc: c, we: 1'b0, dn: 1'b1, lvl: LEVEL_W'(lvl), chk_idx: 1'b0,
                      idx: '0, bsy: 1'b0});
  endtask

  task automatic push_mute(input int c);
    exp_q.push_back('{cyc: c, we: 1'b1, dn: 1'b0, lvl: '0, chk_idx: 1'b0,
                      idx: '0, bsy: 1'b0});
  endtask

  task automatic check_output(input string name, input int act, input int req);
    checks++;
    if (act != req) $display("[TB] FAIL %s: actual %0d, required %0d", name, act, req);
    else passed++;
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, "_level"}, int'(pdm_level), 0);
    check_output({name, "_we"}, int'(pdm_write_en), 0);
    check_output({name, "_busy"}, int'(busy), 0);
    check_output({name, "_idx"}, int'(step_idx), 0);
    check_output({name, "_done"}, int'(done), 0);
  endtask

  task automatic write_cfg(input int addr, input int data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = IDX_W'(addr);
    cfg_data = LEVEL_W'(data);
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Returns at a negedge with the current cycle number; caller queues then pulses start.
  task automatic apply_stimulus(input int h, input int last, input logic lp, output int c);
    @(negedge clk);
    hold     = HOLD_W'(h);
    last_idx = IDX_W'(last);
    loop     = lp;
    c        = cyc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      $display("[TB] FAIL %s_drain: actual %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      passed++;
    end
  endtask

  initial begin
    #1;
    check_all_zero("in_reset");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("after_release");

    write_cfg(0, 3);
    write_cfg(1, 7);
    write_cfg(2, 15);
    write_cfg(3, 31);

    // Basic one-shot run, with an attempted table write while busy.
    apply_stimulus(2, 3, 1'b0, n);
    push_write(n + 1, 3, 0);
    push_write(n + 4, 7, 1);
    push_write(n + 7, 15, 2);
    push_write(n + 10, 31, 3);
    push_done(n + 13, 31);
    pulse_start();
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 5'd9;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_drain("oneshot", 40);
    check_output("level_held", int'(pdm_level), 31);
    check_output("busy_after_done", int'(busy), 0);

    // Stop mid-run mutes the core.
    apply_stimulus(2, 3, 1'b0, n);
    push_write(n + 1, 3, 0);
    push_write(n + 4, 7, 1);
    push_mute(n + 6);
    pulse_start();
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_drain("stop", 40);
    repeat (8) @(negedge clk);

    // Table write in IDLE is taken.
    write_cfg(1, 9);
    apply_stimulus(2, 3, 1'b0, n);
    push_write(n + 1, 3, 0);
    push_write(n + 4, 9, 1);
    push_write(n + 7, 15, 2);
    push_write(n + 10, 31, 3);
    push_done(n + 13, 31);
    pulse_start();
    wait_drain("idle_write", 40);
    write_cfg(1, 7);

    // Looping with hold=0, stop after ten writes takes priority over the eleventh.
    apply_stimulus(0, 3, 1'b1, n);
    for (int i = 0; i < 10; i++) begin
      push_write(n + 1 + i, (i % 4 == 0) ? 3 : (i % 4 == 1) ? 7 : (i % 4 == 2) ? 15 : 31, i % 4);
    end
    push_mute(n + 11);
    pulse_start();
    repeat (9) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_drain("loop", 40);

    // Single-entry sequence with maximum hold.
    apply_stimulus(255, 0, 1'b0, n);
    push_write(n + 1, 3, 0);
    push_done(n + 257, 3);
    pulse_start();
    wait_drain("single", 400);

    // start and stop together in IDLE does nothing.
    @(negedge clk);
    start = 1'b1; stop = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    check_output("start_stop_busy", int'(busy), 0);

    // start held through done restarts on the following cycle.
    apply_stimulus(0, 1, 1'b0, n);
    push_write(n + 1, 3, 0);
    push_write(n + 2, 7, 1);
    push_done(n + 3, 7);
    push_write(n + 4, 3, 0);
    push_write(n + 5, 7, 1);
    push_done(n + 6, 7);
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_drain("restart", 40);

    // Asynchronous reset mid-run clears outputs and the table.
    apply_stimulus(2, 3, 1'b0, n);
    push_write(n + 1, 3, 0);
    push_write(n + 4, 7, 1);
    pulse_start();
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("post_reset_idle");
    wait_drain("reset", 5);

    apply_stimulus(0, 3, 1'b0, n);
    push_write(n + 1, 0, 0);
    push_write(n + 2, 0, 1);
    push_write(n + 3, 0, 2);
    push_write(n + 4, 0, 3);
    push_done(n + 5, 0);
    pulse_start();
    wait_drain("cleared_table", 40);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
